// File: rtl/bcd_xs3_serial_converter.sv
// bcd_xs3_serial_converter: converts a multi-digit word between BCD and Excess-3, one digit per clock, LSD first,
// and flags each invalid input digit.
module bcd_xs3_serial_converter #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_mode,
  input  logic [4*DIGITS-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_data,
  output logic                out_err,
  output logic [DIGITS-1:0]   out_err_mask,
  output logic                busy
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [4*DIGITS-1:0] cap;
  logic mode;
  logic [3:0] dig, res;
  logic bad, last;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = CONV;
      CONV: if (last) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
    busy = state != IDLE;
    out_err = |out_err_mask;
  end
  assign last = idx == IW'(DIGITS - 1);
  assign dig = cap[{idx, 2'b00} +: 4];
  assign bad = mode ? (dig < 4'd3 || dig > 4'd12) : dig > 4'd9;
  assign res = bad ? 4'h0 : mode ? dig - 4'd3 : dig + 4'd3;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cap <= '0;
      mode <= 1'b0;
      idx <= '0;
      out_data <= '0;
      out_err_mask <= '0;
    end else if (state == IDLE && in_valid) begin
      cap <= in_data;
      mode <= in_mode;
      idx <= '0;
      out_data <= '0;
      out_err_mask <= '0;
    end else if (state == CONV) begin
      out_data[{idx, 2'b00} +: 4] <= res;
      out_err_mask[idx] <= bad;
      if (!last) idx <= idx + IW'(1);
    end
endmodule

// File: tb/tb_bcd_xs3_serial_converter.sv
// tb_bcd_xs3_serial_converter: drives DIGITS=1/4/8 instances with directed and random words and compares
// against a digit-wise arithmetic reference.
module tb_bcd_xs3_serial_converter;
  logic clk = 0, rst = 0;
  logic [2:0] ivld = '0, imode = '0, ordy = '0;
  logic [31:0] idat [3];
  logic [2:0] irdy, ovld, oerr, bsy;
  logic [31:0] od [3];
  logic [7:0] om [3];
  logic [3:0] od1;
  logic [0:0] om1;
  logic [15:0] od4;
  logic [3:0] om4;
  logic [31:0] od8;
  logic [7:0] om8;
  int checks = 0, errors = 0;
  int ri;
  logic rm;
  logic [31:0] rd;

  always #5 clk = ~clk;

  assign od[0] = {28'b0, od1};
  assign od[1] = {16'b0, od4};
  assign od[2] = od8;
  assign om[0] = {7'b0, om1};
  assign om[1] = {4'b0, om4};
  assign om[2] = om8;

  bcd_xs3_serial_converter #(.DIGITS(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(ivld[0]), .in_ready(irdy[0]), .in_mode(imode[0]),
    .in_data(idat[0][3:0]), .out_valid(ovld[0]), .out_ready(ordy[0]), .out_data(od1),
    .out_err(oerr[0]), .out_err_mask(om1), .busy(bsy[0]));
  bcd_xs3_serial_converter #(.DIGITS(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(ivld[1]), .in_ready(irdy[1]), .in_mode(imode[1]),
    .in_data(idat[1][15:0]), .out_valid(ovld[1]), .out_ready(ordy[1]), .out_data(od4),
    .out_err(oerr[1]), .out_err_mask(om4), .busy(bsy[1]));
  bcd_xs3_serial_converter #(.DIGITS(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(ivld[2]), .in_ready(irdy[2]), .in_mode(imode[2]),
    .in_data(idat[2]), .out_valid(ovld[2]), .out_ready(ordy[2]), .out_data(od8),
    .out_err(oerr[2]), .out_err_mask(om8), .busy(bsy[2]));

  function automatic int nd(input int i);
    return i == 0 ? 1 : (i == 1 ? 4 : 8);
  endfunction

  // Reference: {err_mask[7:0], result[31:0]} from per-digit arithmetic on the first n digits.
  function automatic logic [39:0] model(input logic m, input logic [31:0] d, input int n);
    logic [31:0] r;
    logic [7:0] e;
    int v;
    r = '0;
    e = '0;
    for (int k = 0; k < n; k++) begin
      v = int'(d[4*k +: 4]);
      if (m ? (v >= 3 && v <= 12) : (v <= 9)) r[4*k +: 4] = 4'(m ? v - 3 : v + 3);
      else e[k] = 1'b1;
    end
    return {e, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int i, input logic m, input logic [31:0] d);
    @(negedge clk);
    chk("in_ready_idle", 32'(irdy[i]), 1);
    ivld[i] = 1'b1;
    imode[i] = m;
    idat[i] = d;
    @(posedge clk);
    #1;
    chk("busy_after_accept", 32'(bsy[i]), 1);
    chk("in_ready_after_accept", 32'(irdy[i]), 0);
    @(negedge clk);
    imode[i] = ~m;
    idat[i] = $urandom;
  endtask

  task automatic finish(input int i, input logic m, input logic [31:0] d, input int hold, input bit keep);
    logic [39:0] e;
    int n;
    e = model(m, d, nd(i));
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ovld[i] && n < 40);
    chk("latency", n, nd(i));
    chk("out_data", od[i], e[31:0]);
    chk("out_err_mask", 32'(om[i]), 32'(e[39:32]));
    chk("out_err", 32'(oerr[i]), 32'(|e[39:32]));
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk("hold_out_valid", 32'(ovld[i]), 1);
      chk("hold_in_ready", 32'(irdy[i]), 0);
      chk("hold_out_data", od[i], e[31:0]);
    end
    @(negedge clk);
    ordy[i] = 1'b1;
    if (!keep) ivld[i] = 1'b0;
    @(posedge clk);
    #1;
    chk("in_ready_after_done", 32'(irdy[i]), 1);
    chk("out_valid_after_done", 32'(ovld[i]), 0);
    chk("out_data_kept", od[i], e[31:0]);
    @(negedge clk);
    ordy[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) idat[i] = '0;
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_out_valid", 32'(ovld[i]), 0);
      chk("reset_busy", 32'(bsy[i]), 0);
      chk("reset_in_ready", 32'(irdy[i]), 1);
      chk("reset_out_data", od[i], 0);
      chk("reset_err_mask", 32'(om[i]), 0);
      chk("reset_out_err", 32'(oerr[i]), 0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send(1, 0, 32'h1234); finish(1, 0, 32'h1234, 0, 0);
    chk("const_4567", od[1], 32'h4567);
    send(1, 1, 32'h4567); finish(1, 1, 32'h4567, 0, 0);
    chk("const_1234", od[1], 32'h1234);
    send(1, 0, 32'h9090); finish(1, 0, 32'h9090, 0, 0);
    chk("const_c3c3", od[1], 32'hC3C3);
    send(1, 0, 32'h9A05); finish(1, 0, 32'h9A05, 0, 0);
    chk("const_c038", od[1], 32'hC038);
    chk("const_mask_0100", 32'(om[1]), 32'h4);
    send(1, 1, 32'h2C3F); finish(1, 1, 32'h2C3F, 0, 0);
    chk("const_0900", od[1], 32'h0900);
    chk("const_mask_1001", 32'(om[1]), 32'h9);
    // backpressure with a new word waiting on the input
    send(1, 0, 32'h0123);
    idat[1] = 32'h5678;
    imode[1] = 1'b1;
    finish(1, 0, 32'h0123, 5, 1);
    @(posedge clk);
    #1;
    chk("bp_next_accept", 32'(bsy[1]), 1);
    @(negedge clk);
    ivld[1] = 1'b0;
    finish(1, 1, 32'h5678, 0, 0);
    chk("const_2345", od[1], 32'h2345);
    send(0, 0, 32'h7); finish(0, 0, 32'h7, 0, 0);
    chk("const_d1_a", od[0], 32'hA);
    send(0, 0, 32'hA); finish(0, 0, 32'hA, 0, 0);
    chk("const_d1_mask", 32'(om[0]), 32'h1);
    send(0, 1, 32'hF); finish(0, 1, 32'hF, 2, 0);
    send(2, 0, 32'h98765432); finish(2, 0, 32'h98765432, 0, 0);
    chk("const_d8", od[2], 32'hCBA98765);
    send(2, 0, 32'h9A051234); finish(2, 0, 32'h9A051234, 1, 0);
    // asynchronous reset while idx==2
    send(1, 0, 32'h3141);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    ivld[1] = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(ovld[1]), 0);
    chk("midrst_busy", 32'(bsy[1]), 0);
    chk("midrst_in_ready", 32'(irdy[1]), 1);
    chk("midrst_out_data", od[1], 0);
    chk("midrst_err_mask", 32'(om[1]), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_valid", 32'(ovld[1]), 0);
    chk("midrst_idle", 32'(bsy[1]), 0);
    send(1, 0, 32'h0999); finish(1, 0, 32'h0999, 0, 0);
    chk("const_3ccc", od[1], 32'h3CCC);
    for (int t = 0; t < 30; t++) begin
      ri = $urandom_range(0, 2);
      rm = 1'($urandom);
      rd = $urandom;
      if ($urandom_range(0, 1) == 1)
        for (int k = 0; k < 8; k++) rd[4*k +: 4] = rm ? 4'(3 + $urandom_range(0, 9)) : 4'($urandom_range(0, 9));
      send(ri, rm, rd);
      finish(ri, rm, rd, $urandom_range(0, 3), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_xs3_serial_converter.md
# bcd_xs3_serial_converter

Parametrised, sequential BCD ↔ Excess-3 code converter for multi-digit words. Accepts a DIGITS-wide packed word over a valid/ready handshake. Converts it one digit per clock, least-significant digit first, in either direction, selected per transaction. Flags every invalid input digit. Sits between the BCD arithmetic datapath and the display and serial-link blocks that consume Excess-3.

## Interface

Parameters:
- DIGITS, 4: number of 4-bit digits per word; legal range ≥1.
- Index counter width is $clog2(DIGITS), with a minimum of 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high. This polarity and synchronicity are fixed.
- in_valid  in  1  input word present.
- in_ready  out  1  converter can accept a word. High only in IDLE.
- in_mode  in  1  direction. 0 = BCD→XS3, 1 = XS3→BCD. Sampled with in_data.
- in_data  in  4*DIGITS  packed digits. Digit k is in_data[4k+3:4k]; digit 0 is the LSD.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_data  out  4*DIGITS  converted digits, same packing as in_data.
- out_err  out  1  OR of out_err_mask.
- out_err_mask  out  DIGITS  bit k set means input digit k was invalid.
- busy  out  1  high in CONV or DONE.

## Operation

- FSM states: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: capture in_data and in_mode into internal registers, clear the result and error registers, set idx=0, go to CONV.
- CONV:
  - Each cycle converts captured digit idx and writes result digit idx and err bit idx.
  - If idx==DIGITS-1, go to DONE; otherwise idx increments.
  - in_valid is ignored.
- DONE:
  - out_valid=1.
  - On out_valid&&out_ready at an edge, go to IDLE.
  - out_data, out_err, and out_err_mask hold stable until that edge and keep their values afterwards, until the next capture clears them.
- Conversion rules, per 4-bit digit d:
  - Mode 0: valid iff d ≤ 9. Result is d+3 (range 3..12).
  - Mode 1: valid iff 3 ≤ d ≤ 12. Result is d−3 (range 0..9).
  - Invalid digit: result is 4'h0 and its err bit is set. Conversion continues for the remaining digits; there is no abort.
  - Arithmetic is 4-bit. Valid inputs never overflow, so no carry propagates between digits.
- Mode is latched at capture. Changing in_mode mid-transaction has no effect.
- DIGITS=1: CONV lasts exactly one cycle.

## Timing

- Reset values:
  - State=IDLE, idx=0.
  - out_valid=0, busy=0.
  - out_data=0, out_err_mask=0, out_err=0.
  - in_ready=1, which follows from state IDLE.
- in_ready, out_valid, and busy are decoded from registered state only. There is no combinational path from in_* or out_ready to any output.
- Latency: with acceptance at edge E0, digit k is written at edge E(k+1), and out_valid rises after edge E(DIGITS).
- Handshake: the earliest completion edge is E(DIGITS+1), and in_ready is high in the next cycle. Peak throughput is one word per DIGITS+2 cycles.
- Backpressure: DONE holds indefinitely while out_ready=0.
- A new word is never accepted in CONV or DONE.
- Reset mid-operation (CONV or DONE):
  - Asynchronous return to IDLE. All outputs take their reset values immediately, without waiting for clk.
  - The partial result is discarded; no out_valid is ever produced for it.
- rst deassertion: the first accept is possible at the first rising edge with rst low.

## Test plan

- DIGITS=4, mode 0, in_data=16'h1234 → out_data=16'h4567, out_err_mask=4'b0000. out_valid rises exactly 4 edges after the accept edge.
- Mode 1, in_data=16'h4567 → out_data=16'h1234, out_err=0. Then mode 0 on 16'h9090 → 16'hC3C3.
- Mode 0, in_data=16'h9A05 → out_data=16'hC038, out_err_mask=4'b0100, out_err=1. Mode 1, in_data=16'h2C3F → out_data=16'h0900, out_err_mask=4'b1001.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while driving in_valid=1 with new data. Required: out_data stable, in_ready=0, new data not captured. Raise out_ready: in_ready=1 in the next cycle, and the new word converts correctly.
- Assert rst for one cycle while idx=2. Required: out_valid=0, busy=0, in_ready=1, and out_data=0 immediately. The following 16'h0999 in mode 0 → 16'h3CCC.
- Re-run the first and third scenarios with DIGITS=1 (4'h7 → 4'hA, latency 1 edge) and with DIGITS=8 (32'h98765432 → 32'hCBA98765, latency 8 edges).
